// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and widths for the PCIe TX requester arbiter.
package pcie_tx_arb_pkg;
  localparam int TLP_DW    = 64;
  localparam int PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OFF_ACK = 2'd2
  } arb_state_e;
endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester above last_owner, wrapping,
// so last_owner itself is considered last.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_owner,
  output logic [NREQ-1:0] pick,
  output logic            valid
);
  logic [IDXW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDXW'((int'(last_owner) + k) % NREQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin mux of NREQ TLP requesters onto the PCIe core TX
// stream, with turn-off handshake and a sent-TLP counter.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_tvalid,
  input  logic [NREQ-1:0]        req_tlast,
  input  logic [NREQ-1:0]        req_1dw,
  input  logic [TLP_DW*NREQ-1:0] req_tdata,
  output logic [NREQ-1:0]        req_tready,
  input  logic                   s_axis_tx_tready,
  output logic [TLP_DW-1:0]      s_axis_tx_tdata,
  output logic                   s_axis_tx_1dw,
  output logic                   s_axis_tx_tlast,
  output logic                   s_axis_tx_tvalid,
  output logic [NREQ-1:0]        grant,
  input  logic                   cfg_to_turnoff,
  output logic                   cfg_turnoff_ok,
  output logic [PKT_CNT_W-1:0]   pkt_count
);
  localparam int IDXW = $clog2(NREQ);

  arb_state_e      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [IDXW-1:0] last_owner, owner_idx, pick_last;
  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic            to_q, to_rise, turnoff_pending, pend_eff;
  logic            fire;

  assign to_rise  = cfg_to_turnoff & ~to_q;
  // A turn-off edge arriving on a final beat must already block the re-grant.
  assign pend_eff = turnoff_pending | to_rise;

  // grant is zero outside GRANT, so every routed output falls to 0 there.
  always_comb begin
    owner_idx       = '0;
    s_axis_tx_tdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_idx       = IDXW'(i);
        s_axis_tx_tdata = req_tdata[i*TLP_DW +: TLP_DW];
      end
    end
  end

  assign s_axis_tx_tvalid = |(grant & req_tvalid);
  assign s_axis_tx_tlast  = |(grant & req_tlast);
  assign s_axis_tx_1dw    = |(grant & req_1dw);
  assign req_tready       = grant & {NREQ{s_axis_tx_tready}};
  assign cfg_turnoff_ok   = (state == OFF_ACK);

  assign fire      = (state == GRANT) & s_axis_tx_tvalid & s_axis_tx_tready & s_axis_tx_tlast;
  assign pick_last = (state == GRANT) ? owner_idx : last_owner;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_pick (
    .req        (req_tvalid),
    .last_owner (pick_last),
    .pick       (pick),
    .valid      (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pend_eff) begin
          state_nxt = OFF_ACK;
        end else if (pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = pick;
        end
      end
      GRANT: begin
        if (fire) begin
          if (pick_vld && !pend_eff) begin
            grant_nxt = pick;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      OFF_ACK: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      grant           <= '0;
      last_owner      <= IDXW'(NREQ-1);
      pkt_count       <= '0;
      to_q            <= 1'b0;
      turnoff_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      to_q  <= cfg_to_turnoff;
      if (fire) begin
        last_owner <= owner_idx;
        pkt_count  <= pkt_count + PKT_CNT_W'(1);
      end
      if (state == OFF_ACK) turnoff_pending <= to_rise;
      else if (to_rise)     turnoff_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter (NREQ=3) with immediate-assertion checks.
module tb_pcie_tx_arbiter;
  localparam int NREQ = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_tvalid, req_tlast, req_1dw, req_tready;
  logic [64*NREQ-1:0] req_tdata;
  logic              s_axis_tx_tready;
  logic [63:0]       s_axis_tx_tdata;
  logic              s_axis_tx_1dw, s_axis_tx_tlast, s_axis_tx_tvalid;
  logic [NREQ-1:0]   grant;
  logic              cfg_to_turnoff, cfg_turnoff_ok;
  logic [15:0]       pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] P2 = 64'h5555_AAAA_5555_AAAA;

  always #5 clock = ~clock;

  pcie_tx_arbiter #(.NREQ(NREQ)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_tvalid       (req_tvalid),
    .req_tlast        (req_tlast),
    .req_1dw          (req_1dw),
    .req_tdata        (req_tdata),
    .req_tready       (req_tready),
    .s_axis_tx_tready (s_axis_tx_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_1dw    (s_axis_tx_1dw),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .grant            (grant),
    .cfg_to_turnoff   (cfg_to_turnoff),
    .cfg_turnoff_ok   (cfg_turnoff_ok),
    .pkt_count        (pkt_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    req_tvalid       = '0;
    req_tlast        = '0;
    req_1dw          = '0;
    req_tdata        = {P2, P1, P0};
    s_axis_tx_tready = 1'b0;
    cfg_to_turnoff   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] beats [4];
    int k, cyc;

    // Reset state, with requests already asserted.
    reset_n          = 1'b0;
    req_tvalid       = 3'b111;
    req_tlast        = 3'b111;
    req_1dw          = '0;
    req_tdata        = {P2, P1, P0};
    s_axis_tx_tready = 1'b1;
    cfg_to_turnoff   = 1'b0;
    #3;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_pkt", 64'(pkt_count), 64'h0);
    chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
    chk("rst_tdata", s_axis_tx_tdata, 64'h0);
    chk("rst_tready", 64'(req_tready), 64'h0);
    chk("rst_ok", 64'(cfg_turnoff_ok), 64'h0);

    // Round robin over three 1-beat requesters.
    step(); reset_n = 1'b1; #1;
    chk("rr_idle_grant", 64'(grant), 64'h0);
    step(); #1;
    chk("rr_g0", 64'(grant), 64'b001);
    chk("rr_d0", s_axis_tx_tdata, P0);
    chk("rr_rdy0", 64'(req_tready), 64'b001);
    step(); #1;
    chk("rr_g1", 64'(grant), 64'b010);
    chk("rr_d1", s_axis_tx_tdata, P1);
    step(); #1;
    chk("rr_g2", 64'(grant), 64'b100);
    chk("rr_d2", s_axis_tx_tdata, P2);
    step(); #1;
    chk("rr_g3", 64'(grant), 64'b001);
    chk("rr_pkt3", 64'(pkt_count), 64'd3);
    step(); #1;
    chk("rr_pkt4", 64'(pkt_count), 64'd4);

    // Lone requester valid on its final beat is re-granted with no gap.
    do_reset();
    req_tvalid = 3'b001; req_tlast = 3'b001; s_axis_tx_tready = 1'b1;
    step(); #1;
    chk("b2b_g_first", 64'(grant), 64'b001);
    step(); #1;
    chk("b2b_g_again", 64'(grant), 64'b001);
    chk("b2b_pkt", 64'(pkt_count), 64'd1);

    // Port 1 3-beat TLP; port 0 arrives mid-packet and must wait.
    do_reset();
    req_tvalid = 3'b010; s_axis_tx_tready = 1'b1;
    step(); #1;
    chk("hold_g_b1", 64'(grant), 64'b010);
    step(); req_tvalid = 3'b011; #1;
    chk("hold_rdy_b2", 64'(req_tready), 64'b010);
    step(); req_tlast = 3'b011; #1;
    chk("hold_rdy_b3", 64'(req_tready), 64'b010);
    chk("hold_tlast", 64'(s_axis_tx_tlast), 64'h1);
    step(); #1;
    chk("hold_g_next", 64'(grant), 64'b001);
    chk("hold_d_next", s_axis_tx_tdata, P0);
    chk("hold_pkt", 64'(pkt_count), 64'd1);

    // 4-beat TLP on port 2 with core ready toggling 1,0,1,0...
    do_reset();
    beats[0] = 64'h1000_0000_0000_0000; beats[1] = 64'h1000_0000_0000_0001;
    beats[2] = 64'h1000_0000_0000_0002; beats[3] = 64'h1000_0000_0000_0003;
    req_tvalid = 3'b100;
    req_tdata[128 +: 64] = beats[0];
    step();
    k = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      s_axis_tx_tready = (cyc % 2 == 0);
      req_tdata[128 +: 64] = beats[k];
      req_tlast = (k == 3) ? 3'b100 : 3'b000;
      req_1dw   = (k == 3) ? 3'b100 : 3'b000;
      #1;
      chk("tgl_rdy", 64'(req_tready), {61'h0, s_axis_tx_tready, 2'b00});
      if (s_axis_tx_tvalid && s_axis_tx_tready) begin
        chk("tgl_data", s_axis_tx_tdata, beats[k]);
        chk("tgl_last", 64'(s_axis_tx_tlast), 64'(k == 3));
        chk("tgl_1dw", 64'(s_axis_tx_1dw), 64'(k == 3));
        k++;
      end
      cyc++;
      step();
    end
    #1;
    chk("tgl_beats", 64'(k), 64'd4);
    chk("tgl_cycles", 64'(cyc), 64'd7);
    chk("tgl_pkt", 64'(pkt_count), 64'd1);

    // Turn-off raised mid-TLP with other requests pending.
    do_reset();
    req_tvalid = 3'b111; s_axis_tx_tready = 1'b1;
    step(); cfg_to_turnoff = 1'b1; #1;
    chk("off_g_b1", 64'(grant), 64'b001);
    step(); req_tlast = 3'b111; #1;
    chk("off_g_b2", 64'(grant), 64'b001);
    chk("off_ok_b2", 64'(cfg_turnoff_ok), 64'h0);
    step(); #1;
    chk("off_nogrant", 64'(grant), 64'h0);
    chk("off_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
    chk("off_ok_idle", 64'(cfg_turnoff_ok), 64'h0);
    step(); #1;
    chk("off_ok_hi", 64'(cfg_turnoff_ok), 64'h1);
    chk("off_g_ack", 64'(grant), 64'h0);
    step(); #1;
    chk("off_ok_lo", 64'(cfg_turnoff_ok), 64'h0);
    chk("off_g_idle2", 64'(grant), 64'h0);
    step(); #1;
    chk("off_resume", 64'(grant), 64'b010);

    // Turn-off edge coincident with a final beat.
    do_reset();
    req_tvalid = 3'b111; req_tlast = 3'b111; s_axis_tx_tready = 1'b1;
    step(); cfg_to_turnoff = 1'b1; #1;
    chk("coin_g", 64'(grant), 64'b001);
    step(); #1;
    chk("coin_nogrant", 64'(grant), 64'h0);
    chk("coin_pkt", 64'(pkt_count), 64'd1);
    step(); #1;
    chk("coin_ok", 64'(cfg_turnoff_ok), 64'h1);

    // Counter wrap after 65535 + 1 TLPs.
    do_reset();
    req_tvalid = 3'b111; req_tlast = 3'b111; s_axis_tx_tready = 1'b1;
    step();
    repeat (65535) step();
    #1;
    chk("wrap_ffff", 64'(pkt_count), 64'hFFFF);
    step(); #1;
    chk("wrap_0000", 64'(pkt_count), 64'h0);

    // Reset during beat 2 of a port 1 TLP.
    do_reset();
    req_tvalid = 3'b010; s_axis_tx_tready = 1'b1;
    step(); #1;
    chk("mid_g_b1", 64'(grant), 64'b010);
    step(); #1;
    chk("mid_tvalid_b2", 64'(s_axis_tx_tvalid), 64'h1);
    reset_n = 1'b0; #1;
    chk("mid_rst_tvalid", 64'(s_axis_tx_tvalid), 64'h0);
    chk("mid_rst_tdata", s_axis_tx_tdata, 64'h0);
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_pkt", 64'(pkt_count), 64'h0);
    req_tvalid = 3'b011;
    step(); reset_n = 1'b1;
    step(); #1;
    chk("mid_port0_first", 64'(grant), 64'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
